// File: rtl/mem_wb_elastic_reg.sv
// MEM->WB elastic boundary register: two-entry (main + skid) stage with valid/ready
// handshake, synchronous flush, x0-write suppression and a resolved writeback-result mux.
module mem_wb_elastic_reg #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int LINK_W      = 32,
    parameter int ZERO_REG_RO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              reg_write_M,
    input  logic              mem_to_reg_M,
    input  logic              jump_M,
    input  logic [LINK_W-1:0] link_M,
    input  logic [DATA_W-1:0] read_data_M,
    input  logic [DATA_W-1:0] alu_out_M,
    input  logic [REG_AW-1:0] write_reg_M,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              reg_write_W,
    output logic [REG_AW-1:0] write_reg_W,
    output logic [DATA_W-1:0] wb_data_W,
    output logic              mem_to_reg_W,
    output logic              jump_W
);

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              jump;
        logic [LINK_W-1:0] link;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
        logic [REG_AW-1:0] write_reg;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_n;
    entry_t            in_entry;
    entry_t            main_p1, skid_p1;
    logic              in_ready_q;
    logic              accept, consume;
    logic              load_main_in, load_main_skid, load_skid;
    logic [DATA_W-1:0] link_ext;

    function automatic logic [DATA_W-1:0] select_result(
        input logic              jump,
        input logic              mem_to_reg,
        input logic [DATA_W-1:0] link_val,
        input logic [DATA_W-1:0] read_data,
        input logic [DATA_W-1:0] alu_out
    );
        if (jump)
            return link_val;
        else if (mem_to_reg)
            return read_data;
        else
            return alu_out;
    endfunction

    assign in_entry = '{reg_write:  reg_write_M,
                        mem_to_reg: mem_to_reg_M,
                        jump:       jump_M,
                        link:       link_M,
                        read_data:  read_data_M,
                        alu_out:    alu_out_M,
                        write_reg:  write_reg_M};

    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign consume   = out_valid & out_ready;

    always_comb begin
        state_n        = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main_in = 1'b1;
                    state_n      = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end else if (consume) begin
                    state_n = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    load_main_skid = 1'b1;
                    state_n        = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    // Stage boundary: main/skid entries; flush kills control bits but leaves data fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            main_p1    <= '0;
            skid_p1    <= '0;
        end else if (flush) begin
            state              <= EMPTY;
            in_ready_q         <= 1'b1;
            main_p1.reg_write  <= 1'b0;
            main_p1.mem_to_reg <= 1'b0;
            main_p1.jump       <= 1'b0;
            skid_p1.reg_write  <= 1'b0;
            skid_p1.mem_to_reg <= 1'b0;
            skid_p1.jump       <= 1'b0;
        end else begin
            state      <= state_n;
            in_ready_q <= (state_n != FULL);
            if (load_main_in)
                main_p1 <= in_entry;
            else if (load_main_skid)
                main_p1 <= skid_p1;
            if (load_skid)
                skid_p1 <= in_entry;
        end
    end

    generate
        if (LINK_W >= DATA_W) begin : g_link_trunc
            assign link_ext = main_p1.link[DATA_W-1:0];
        end else begin : g_link_zext
            assign link_ext = {{(DATA_W-LINK_W){1'b0}}, main_p1.link};
        end
    endgenerate

    assign write_reg_W  = main_p1.write_reg;
    assign mem_to_reg_W = main_p1.mem_to_reg;
    assign jump_W       = main_p1.jump;
    assign reg_write_W  = out_valid & main_p1.reg_write &
                          !((ZERO_REG_RO != 0) && (main_p1.write_reg == '0));
    assign wb_data_W    = select_result(main_p1.jump, main_p1.mem_to_reg, link_ext,
                                        main_p1.read_data, main_p1.alu_out);

endmodule
